// File: rtl/ethernet_ipv4_framer.sv
// Ethernet II + IPv4 transmit framer: prepends a 34-byte header to a TCP segment
// stream and zero-pads frames to the 60-byte minimum (the MAC appends the FCS).
//
// state   | meaning
// IDLE    | waiting for a metadata beat
// CSUM    | one cycle to compute the IPv4 header checksum
// HDR     | emitting the 34 header bytes
// PAYLOAD | passing segment bytes straight through
// PAD     | emitting zero bytes up to the frame length
// DRAIN   | discarding segment bytes through tlast
module ethernet_ipv4_framer #(
  parameter logic [7:0] TTL         = 8'd64,
  parameter int         MAX_SEG_LEN = 1480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meta_valid,
  output logic        meta_ready,
  input  logic [47:0] meta_dst_mac,
  input  logic [47:0] meta_src_mac,
  input  logic [31:0] meta_src_ip,
  input  logic [31:0] meta_dst_ip,
  input  logic [7:0]  meta_protocol,
  input  logic [15:0] meta_seg_len,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        err_len,
  output logic        err_oversize
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_SEG_LEN);

  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, PAD, DRAIN} state_t;

  state_t       state;
  logic [47:0]  dst_mac, src_mac;
  logic [31:0]  src_ip, dst_ip;
  logic [7:0]   protocol;
  logic [10:0]  seg_len, byte_cnt, frame_len, pay_cnt;
  logic [15:0]  ident, csum, csum_calc, total_len;
  logic         drain_to_pad, last_byte, m_hs;
  logic [271:0] hdr_vec;
  logic [5:0]   hdr_sel;
  logic [19:0]  sum20;
  logic [16:0]  fold1;
  logic [15:0]  fold2;

  assign total_len = {5'd0, seg_len} + 16'd20;
  assign frame_len = (seg_len < 11'd26) ? 11'd60 : seg_len + 11'd34;
  assign last_byte = (byte_cnt + 11'd1) == frame_len;
  // payload bytes delivered once the current beat completes
  assign pay_cnt   = byte_cnt - 11'd33;
  assign m_hs      = m_axis_tvalid & m_axis_tready;
  assign hdr_sel   = 6'd33 - byte_cnt[5:0];

  assign hdr_vec = {dst_mac, src_mac, 16'h0800,
                    16'h4500, total_len, ident, 16'h4000,
                    TTL, protocol, csum, src_ip, dst_ip};

  always_comb begin
    sum20 = 20'h04500 + {4'd0, total_len} + {4'd0, ident} + 20'h04000
          + {4'd0, TTL, protocol}
          + {4'd0, src_ip[31:16]} + {4'd0, src_ip[15:0]}
          + {4'd0, dst_ip[31:16]} + {4'd0, dst_ip[15:0]};
    fold1 = {1'b0, sum20[15:0]} + {13'd0, sum20[19:16]};
    // a second carry out of the first fold is impossible, so 16 bits suffice
    fold2 = fold1[15:0] + {15'd0, fold1[16]};
    csum_calc = ~fold2;
  end

  always_comb begin
    meta_ready    = (state == IDLE);
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    case (state)
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_vec[{hdr_sel, 3'b000} +: 8];
      end
      PAYLOAD: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = last_byte;
        s_axis_tready = m_axis_tready;
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = last_byte;
      end
      DRAIN: s_axis_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dst_mac      <= '0;
      src_mac      <= '0;
      src_ip       <= '0;
      dst_ip       <= '0;
      protocol     <= '0;
      seg_len      <= '0;
      byte_cnt     <= '0;
      ident        <= '0;
      csum         <= '0;
      drain_to_pad <= 1'b0;
      err_len      <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      err_len      <= 1'b0;
      err_oversize <= 1'b0;
      case (state)
        IDLE: if (meta_valid) begin
          dst_mac      <= meta_dst_mac;
          src_mac      <= meta_src_mac;
          src_ip       <= meta_src_ip;
          dst_ip       <= meta_dst_ip;
          protocol     <= meta_protocol;
          seg_len      <= meta_seg_len[10:0];
          drain_to_pad <= 1'b0;
          if (meta_seg_len > MAX_LEN) begin
            err_oversize <= 1'b1;
            state        <= DRAIN;
          end else begin
            state <= CSUM;
          end
        end
        CSUM: begin
          csum     <= csum_calc;
          byte_cnt <= '0;
          state    <= HDR;
        end
        HDR: if (m_hs) begin
          byte_cnt <= byte_cnt + 11'd1;
          if (byte_cnt == 11'd33) state <= (seg_len != '0) ? PAYLOAD : PAD;
        end
        PAYLOAD: if (m_hs) begin
          byte_cnt <= byte_cnt + 11'd1;
          if (pay_cnt == seg_len) begin
            if (!s_axis_tlast) begin
              // excess bytes: finish the frame if complete, pad later otherwise
              err_len      <= 1'b1;
              drain_to_pad <= !last_byte;
              state        <= DRAIN;
              if (last_byte) ident <= ident + 16'd1;
            end else if (last_byte) begin
              ident <= ident + 16'd1;
              state <= IDLE;
            end else begin
              state <= PAD;
            end
          end else if (s_axis_tlast) begin
            err_len <= 1'b1;
            state   <= PAD;
          end
        end
        PAD: if (m_hs) begin
          byte_cnt <= byte_cnt + 11'd1;
          if (last_byte) begin
            ident <= ident + 16'd1;
            state <= IDLE;
          end
        end
        DRAIN: if (s_axis_tvalid && s_axis_tlast) state <= drain_to_pad ? PAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_ipv4_framer.sv
// Randomized bench for ethernet_ipv4_framer: each frame is compared byte for byte
// against a frame built from the protocol rules (header layout, checksum, padding).
module tb_ethernet_ipv4_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meta_valid = 1'b0;
  logic        meta_ready;
  logic [47:0] meta_dst_mac = '0, meta_src_mac = '0;
  logic [31:0] meta_src_ip = '0, meta_dst_ip = '0;
  logic [7:0]  meta_protocol = '0;
  logic [15:0] meta_seg_len = '0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic        err_len, err_oversize;

  int errors = 0;
  int checks = 0;
  logic [15:0] ident_model = '0;
  logic [7:0]  got_q[$], exp_q[$], pay_q[$];

  ethernet_ipv4_framer dut (
    .clk(clk), .rst_n(rst_n),
    .meta_valid(meta_valid), .meta_ready(meta_ready),
    .meta_dst_mac(meta_dst_mac), .meta_src_mac(meta_src_mac),
    .meta_src_ip(meta_src_ip), .meta_dst_ip(meta_dst_ip),
    .meta_protocol(meta_protocol), .meta_seg_len(meta_seg_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .err_len(err_len), .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void build_expected(input logic [47:0] dmac, input logic [47:0] smac,
                                         input logic [31:0] sip, input logic [31:0] dip,
                                         input logic [7:0] proto, input int seg_len,
                                         input int n_sent, input logic [15:0] id);
    logic [15:0] w[10];
    logic [31:0] s;
    int flen;
    exp_q.delete();
    for (int i = 5; i >= 0; i--) exp_q.push_back(dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(smac[i*8 +: 8]);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    w[0] = 16'h4500; w[1] = 16'(20 + seg_len); w[2] = id; w[3] = 16'h4000;
    w[4] = {8'd64, proto}; w[5] = 16'h0000;
    w[6] = sip[31:16]; w[7] = sip[15:0]; w[8] = dip[31:16]; w[9] = dip[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += {16'd0, w[i]};
    while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
    w[5] = ~s[15:0];
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(w[i][15:8]);
      exp_q.push_back(w[i][7:0]);
    end
    for (int i = 0; i < seg_len && i < n_sent; i++) exp_q.push_back(pay_q[i]);
    flen = (34 + seg_len < 60) ? 60 : 34 + seg_len;
    while (exp_q.size() < flen) exp_q.push_back(8'h00);
  endfunction

  task automatic run_frame(input logic [47:0] dmac, input logic [47:0] smac,
                           input logic [31:0] sip, input logic [31:0] dip,
                           input logic [7:0] proto, input int seg_len,
                           input int n_sent, input int ready_pct);
    bit oversize, meta_done, tlast_seen, done, prev_stall, s_hs, meta_hs;
    int s_idx, cyc, hs_cyc, first_cyc, n_tlast, tlast_at, nerr_len, nerr_ov, bad_valid;
    logic [7:0] prev_data;
    meta_done = 0; tlast_seen = 0; done = 0; prev_stall = 0; prev_data = '0;
    s_idx = 0; hs_cyc = 0; first_cyc = -1; n_tlast = 0; tlast_at = -1;
    nerr_len = 0; nerr_ov = 0; bad_valid = 0;
    pay_q.delete();
    for (int i = 0; i < n_sent; i++) pay_q.push_back(8'($urandom_range(255)));
    oversize = seg_len > 1480;
    if (!oversize) build_expected(dmac, smac, sip, dip, proto, seg_len, n_sent, ident_model);
    got_q.delete();
    meta_dst_mac = dmac; meta_src_mac = smac; meta_src_ip = sip; meta_dst_ip = dip;
    meta_protocol = proto; meta_seg_len = 16'(seg_len); meta_valid = 1'b1;
    s_axis_tvalid = (n_sent > 0);
    s_axis_tdata  = (n_sent > 0) ? pay_q[0] : 8'h00;
    s_axis_tlast  = (n_sent == 1);
    m_axis_tready = ($urandom_range(99) < ready_pct);
    for (cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clk);
      meta_hs = meta_valid && meta_ready;
      if (meta_hs) hs_cyc = cyc;
      if (m_axis_tvalid && first_cyc < 0) first_cyc = cyc;
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(m_axis_tdata);
        if (m_axis_tlast) begin
          n_tlast++;
          tlast_at = got_q.size() - 1;
          tlast_seen = 1;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      s_hs = s_axis_tvalid && s_axis_tready;
      if (err_len) nerr_len++;
      if (err_oversize) nerr_ov++;
      if (oversize && m_axis_tvalid) bad_valid++;
      @(posedge clk);
      #1;
      if (meta_hs) begin
        meta_valid = 1'b0;
        meta_done  = 1;
      end
      if (s_hs) begin
        s_idx++;
        if (s_idx < n_sent) begin
          s_axis_tdata = pay_q[s_idx];
          s_axis_tlast = (s_idx == n_sent - 1);
        end else begin
          s_axis_tvalid = 1'b0;
          s_axis_tlast  = 1'b0;
        end
      end
      m_axis_tready = ($urandom_range(99) < ready_pct);
      done = meta_done && (s_idx == n_sent) && (oversize || tlast_seen);
    end
    chk("frame_done", done, 1);
    chk("s_consumed", s_idx, n_sent);
    if (!oversize) begin
      chk("frame_len", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        chk($sformatf("byte%0d", i), got_q[i], exp_q[i]);
      chk("tlast_pos", tlast_at, exp_q.size() - 1);
      chk("tlast_cnt", n_tlast, 1);
      chk("latency", first_cyc - hs_cyc, 2);
      chk("err_len", nerr_len, (n_sent != seg_len) ? 1 : 0);
      chk("err_ov_none", nerr_ov, 0);
      ident_model = ident_model + 16'd1;
    end else begin
      chk("ov_no_valid", bad_valid, 0);
      chk("err_ov", nerr_ov, 1);
      chk("ov_err_len", nerr_len, 0);
      @(negedge clk);
      chk("ov_meta_ready", meta_ready, 1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit hit, mhs;
    int cnt, seg, n, r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_meta_ready", meta_ready, 1);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_err_ov", err_oversize, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(48'h0200_0000_0001, 48'h0200_0000_0002, 32'hC0A80001, 32'hC0A800C7, 8'h11, 95, 95, 100);
    chk("t1_len", got_q.size(), 129);
    chk("t1_tl_hi", got_q[16], 8'h00);
    chk("t1_tl_lo", got_q[17], 8'h73);
    chk("t1_cs_hi", got_q[24], 8'hB8);
    chk("t1_cs_lo", got_q[25], 8'h61);

    run_frame(48'h0011_2233_4455, 48'h6677_8899_AABB, 32'h0A000001, 32'h0A000002, 8'h06, 4, 4, 100);
    chk("t2_len", got_q.size(), 60);
    chk("t2_tl_lo", got_q[17], 8'h18);
    run_frame(48'h0011_2233_4455, 48'h6677_8899_AABB, 32'h0A000001, 32'h0A000002, 8'h06, 20, 20, 100);
    chk("t3_ident_lo", got_q[19], 8'h02);

    run_frame(48'h0200_0000_0001, 48'h0200_0000_0002, 32'hC0A80001, 32'hC0A800C7, 8'h11, 95, 95, 50);
    run_frame(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 32'h01020304, 32'h05060708, 8'h06, 10, 6, 80);
    chk("early_len", got_q.size(), 60);
    run_frame(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 32'h01020304, 32'h05060708, 8'h06, 4, 8, 80);
    run_frame(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 32'h01020304, 32'h05060708, 8'h06, 0, 0, 70);
    run_frame(48'hC1C2_C3C4_C5C6, 48'hD1D2_D3D4_D5D6, 32'h11223344, 32'h55667788, 8'h06, 1500, 30, 100);
    run_frame(48'hC1C2_C3C4_C5C6, 48'hD1D2_D3D4_D5D6, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 1480, 1480, 100);

    for (int k = 0; k < 10; k++) begin
      seg = $urandom_range(1, 300);
      r = $urandom_range(2);
      n = (r == 0) ? seg : (r == 1) ? seg + $urandom_range(1, 5) : $urandom_range(1, seg);
      run_frame({$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, $urandom, $urandom,
                8'($urandom), seg, n, $urandom_range(30, 100));
    end

    force dut.ident = 16'hFFFF;
    @(negedge clk);
    release dut.ident;
    @(posedge clk);
    #1;
    ident_model = 16'hFFFF;
    run_frame(48'h0200_0000_0009, 48'h0200_0000_000A, 32'hC0A80001, 32'hC0A800C7, 8'h11, 30, 30, 100);
    chk("wrap_ff_hi", got_q[18], 8'hFF);
    chk("wrap_ff_lo", got_q[19], 8'hFF);
    run_frame(48'h0200_0000_0009, 48'h0200_0000_000A, 32'hC0A80001, 32'hC0A800C7, 8'h11, 30, 30, 100);
    chk("wrap_00_hi", got_q[18], 8'h00);
    chk("wrap_00_lo", got_q[19], 8'h00);

    meta_seg_len = 16'd40; meta_valid = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    cnt = 0; hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (m_axis_tvalid && cnt == 10) begin
        hit = 1;
      end else begin
        mhs = meta_valid && meta_ready;
        if (m_axis_tvalid && m_axis_tready) cnt++;
        @(posedge clk);
        #1;
        if (mhs) meta_valid = 1'b0;
      end
    end
    chk("rst_reach_b10", hit, 1);
    rst_n = 1'b0;
    meta_valid = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_axis_tvalid, 0);
    chk("midrst_m_tlast", m_axis_tlast, 0);
    chk("midrst_meta_ready", meta_ready, 1);
    chk("midrst_s_tready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ident_model = 16'h0000;
    @(negedge clk);
    chk("post_rst_meta_ready", meta_ready, 1);
    @(posedge clk);
    #1;
    run_frame(48'h0200_0000_0005, 48'h0200_0000_0006, 32'hC0A80001, 32'hC0A800C7, 8'h11, 12, 12, 100);
    chk("post_rst_ident", got_q[19], 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
